imem_loader: RTL and testbench

Boot-time instruction-memory loader sitting directly upstream of the pipelined CPU. It clears the 256-word instruction memory, fills it from a valid/ready word stream, and holds the CPU in reset until the image is resident. It then releases reset and raises start, so the CPU begins at PC 0 with a fully written memory. It replaces the behavioural memory preload and start/reset sequencing with synthesizable logic.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_csum.sv | 35 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Contents: loader state enum, error-code constants, default geometry.
package imem_loader_pkg;

    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW = 2'b01;
    localparam logic [1:0] ERR_CSUM     = 2'b10;

    // CHECK is only ever entered when the checksum option is built in.
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        CHECK,
        FINISH,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// rtl/imem_loader_csum.sv - modular running sum of image words with compare
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        zero the sum (start of a new load)
//   add_i          accumulate data_i this cycle
//   data_i         stream word; also the value compared against the sum
//   match_o        data_i equals the current sum
module imem_loader_csum
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              match_o
);

    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum <= '0;
        end else if (clear_i) begin
            sum <= '0;
        end else if (add_i) begin
            sum <= sum + data_i;
        end
    end

    assign match_o = (data_i == sum);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction-memory clear/load and CPU start sequencer
// Option macro: IMEM_LOADER_CHECKSUM_EN (adds trailing checksum word and CHECK state)
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   go_i                         pulse: begin clear+load (honoured in IDLE, RUN, ERR)
//   data_i, valid_i, last_i      image word stream; ready_o is the handshake return
//   we_o, waddr_o, wdata_o       registered instruction-memory write port
//   cpu_rst_o, start_o           CPU reset and start controls
//   done_o                       image resident and CPU running
//   error_o                      00 none, 01 overflow, 10 checksum mismatch
//   word_count_o                 image words written
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              go_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              cpu_rst_o,
    output logic              start_o,
    output logic              done_o,
    output logic [1:0]        error_o,
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic csum_match;
    logic csum_clear;

    assign csum_clear = go_i && ((state == IDLE) || (state == RUN) || (state == ERR));

    imem_loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (csum_clear),
        .add_i   ((state == LOAD) && valid_i),
        .data_i  (data_i),
        .match_o (csum_match)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            addr         <= '0;
            ready_o      <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= '0;
            wdata_o      <= '0;
            cpu_rst_o    <= 1'b1;
            start_o      <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= ERR_NONE;
            word_count_o <= '0;
        end else begin
            we_o <= 1'b0;
            case (state)
                // Restart is allowed from rest states only; the CPU goes back
                // into reset on the same edge that leaves RUN.
                IDLE, RUN, ERR: begin
                    if (go_i) begin
                        state        <= CLEAR;
                        addr         <= '0;
                        word_count_o <= '0;
                        error_o      <= ERR_NONE;
                        cpu_rst_o    <= 1'b1;
                        start_o      <= 1'b0;
                        done_o       <= 1'b0;
                        ready_o      <= 1'b0;
                    end
                end
                CLEAR: begin
                    we_o    <= 1'b1;
                    waddr_o <= addr;
                    wdata_o <= '0;
                    addr    <= addr + ADDR_ONE;   // wraps to 0 for LOAD
                    if (addr == LAST_ADDR) begin
                        state   <= LOAD;
                        ready_o <= 1'b1;
                    end
                end
                LOAD: begin
                    if (valid_i) begin
                        we_o         <= 1'b1;
                        waddr_o      <= addr;
                        wdata_o      <= data_i;
                        addr         <= addr + ADDR_ONE;
                        word_count_o <= word_count_o + CNT_ONE;
                        // last_i wins at the top address: a full-depth image is legal.
                        if (last_i) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state   <= CHECK;
`else
                            state   <= FINISH;
                            ready_o <= 1'b0;
`endif
                        end else if (addr == LAST_ADDR) begin
                            state   <= ERR;
                            error_o <= ERR_OVERFLOW;
                            ready_o <= 1'b0;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                // The checksum word is consumed but never written to memory.
                CHECK: begin
                    if (valid_i) begin
                        ready_o <= 1'b0;
                        if (csum_match) begin
                            state <= FINISH;
                        end else begin
                            state   <= ERR;
                            error_o <= ERR_CSUM;
                        end
                    end
                end
`endif
                // The final image write is on the port during this cycle, so
                // the CPU leaves reset only once it has landed.
                FINISH: begin
                    state     <= RUN;
                    cpu_rst_o <= 1'b0;
                    start_o   <= 1'b1;
                    done_o    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              go_i = 1'b0;
    logic [DATA_W-1:0] data_i = '0;
    logic              valid_i = 1'b0;
    logic              last_i = 1'b0;
    logic              ready_o;
    logic              we_o;
    logic [ADDR_W-1:0] waddr_o;
    logic [DATA_W-1:0] wdata_o;
    logic              cpu_rst_o;
    logic              start_o;
    logic              done_o;
    logic [1:0]        error_o;
    logic [ADDR_W:0]   word_count_o;

    imem_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .go_i         (go_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .start_o      (start_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Observed memory and write log, captured mid-cycle.
    logic [DATA_W-1:0] obs_mem [DEPTH];
    int                wr_addr_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    logic [DATA_W-1:0] img[$];
    int                vpat[$];

    always @(negedge clk_i) begin
        if (we_o === 1'b1) begin
            obs_mem[waddr_o] = wdata_o;
            wr_addr_q.push_back(int'(waddr_o));
            wr_data_q.push_back(wdata_o);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic reset_dut();
        rst_i = 1'b1; go_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic pulse_go();
        @(negedge clk_i);
        wr_addr_q.delete();
        wr_data_q.delete();
        go_i = 1'b1;
        @(negedge clk_i);
        go_i = 1'b0;
    endtask

    // Called at the negedge just after the go edge; LOAD must start DEPTH cycles later.
    task automatic wait_ready(input string name);
        int cyc = 0;
        while (ready_o !== 1'b1 && cyc < 1000) begin
            @(negedge clk_i);
            cyc++;
        end
        checks++;
        if (cyc !== DEPTH) begin
            errors++;
            $display("FAIL %s clear_len: got %0d cycles expected %0d", name, cyc, DEPTH);
        end
    endtask

    // mode 0: valid always high, 1: random valid, 2: cyclic vpat pattern.
    task automatic send_img(input bit set_last, input int mode, output int cycles);
        int idx = 0;
        int pi = 0;
        bit v;
        bit rdy;
        cycles = 0;
        while (idx < img.size() && cycles < 4000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: begin v = (vpat[pi % vpat.size()] != 0); pi++; end
            endcase
            valid_i = v;
            data_i  = v ? img[idx] : $urandom;
            last_i  = v ? (set_last && idx == img.size() - 1) : 1'($urandom_range(0, 1));
            rdy     = ready_o;
            @(negedge clk_i);
            cycles++;
            if (v && rdy) idx++;
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        checks++;
        if (idx !== img.size()) begin
            errors++;
            $display("FAIL send_img: sent %0d words expected %0d", idx, img.size());
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    function automatic logic [DATA_W-1:0] model_sum();
        logic [DATA_W-1:0] s = '0;
        foreach (img[i]) s = s + img[i];
        return s;
    endfunction

    task automatic send_check_word(input logic [DATA_W-1:0] w);
        int guard = 0;
        while (ready_o !== 1'b1 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL check_ready: ready_o=%b expected 1", ready_o);
        end
        valid_i = 1'b1; data_i = w; last_i = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask
`endif

    task automatic send_image(input int mode, output int cycles);
        send_img(1'b1, mode, cycles);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_check_word(model_sum());
`endif
    endtask

    // Entered at the negedge after the final accepted word: FINISH now, RUN next.
    task automatic check_run_timing(input string name);
        checks++;
        if (start_o !== 1'b0 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL %s finish: start_o=%b cpu_rst_o=%b expected 0 1", name, start_o, cpu_rst_o);
        end
        @(negedge clk_i);
        checks++;
        if ({start_o, cpu_rst_o, done_o, ready_o, error_o} !== 6'b101000) begin
            errors++;
            $display("FAIL %s run: start=%b cpu_rst=%b done=%b ready=%b err=%b expected 1 0 1 0 00",
                     name, start_o, cpu_rst_o, done_o, ready_o, error_o);
        end
        checks++;
        if (int'(word_count_o) !== img.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d expected %0d", name, word_count_o, img.size());
        end
    endtask

    // Expected: DEPTH zero writes in address order, then image words from 0.
    task automatic check_load(input string name);
        int n = img.size();
        int bad_clr = 0;
        int bad_img = 0;
        int bad_mem = 0;
        logic [DATA_W-1:0] exp;
        checks++;
        if (wr_addr_q.size() !== DEPTH + n) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_q.size(), DEPTH + n);
        end
        for (int i = 0; i < DEPTH && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] != i || wr_data_q[i] != '0) bad_clr++;
        for (int i = 0; i < n && DEPTH + i < wr_addr_q.size(); i++)
            if (wr_addr_q[DEPTH + i] != i || wr_data_q[DEPTH + i] !== img[i]) bad_img++;
        for (int a = 0; a < DEPTH; a++) begin
            exp = (a < n) ? img[a] : '0;
            if (obs_mem[a] !== exp) bad_mem++;
        end
        checks++;
        if (bad_clr !== 0) begin
            errors++;
            $display("FAIL %s clear_writes: %0d bad entries expected 0", name, bad_clr);
        end
        checks++;
        if (bad_img !== 0) begin
            errors++;
            $display("FAIL %s image_writes: %0d bad entries expected 0", name, bad_img);
        end
        checks++;
        if (bad_mem !== 0) begin
            errors++;
            $display("FAIL %s memory: %0d bad words expected 0", name, bad_mem);
        end
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic test_reset();
        reset_dut();
        wr_addr_q.delete();
        wr_data_q.delete();
        repeat (10) @(negedge clk_i);
        checks++;
        if (wr_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL reset we_o: %0d writes seen expected 0", wr_addr_q.size());
        end
        checks++;
        if ({ready_o, we_o, cpu_rst_o, start_o, done_o} !== 5'b00100) begin
            errors++;
            $display("FAIL reset ctrl: ready=%b we=%b cpu_rst=%b start=%b done=%b expected 0 0 1 0 0",
                     ready_o, we_o, cpu_rst_o, start_o, done_o);
        end
        checks++;
        if (waddr_o !== '0 || wdata_o !== '0 || error_o !== 2'b00 || word_count_o !== '0) begin
            errors++;
            $display("FAIL reset data: waddr=%h wdata=%h err=%b count=%0d expected all 0",
                     waddr_o, wdata_o, error_o, word_count_o);
        end
    endtask

    task automatic test_basic();
        int cyc;
        img.delete();
        img.push_back(32'h0050_0093);
        img.push_back(32'h0010_8133);
        img.push_back(32'h0000_0013);
        pulse_go();
        wait_ready("basic");
        send_image(0, cyc);
        check_run_timing("basic");
        check_load("basic");
    endtask

    task automatic test_gaps();
        int cyc;
        pulse_go();
        wait_ready("gaps");
        go_i = 1'b1;
        @(negedge clk_i);
        go_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || word_count_o !== '0) begin
            errors++;
            $display("FAIL gaps go_in_load: ready=%b count=%0d expected 1 0", ready_o, word_count_o);
        end
        vpat = '{1, 0, 0, 1, 0, 1};
        send_img(1'b1, 2, cyc);
        checks++;
        if (cyc !== 6) begin
            errors++;
            $display("FAIL gaps stream_cycles: got %0d expected 6", cyc);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_check_word(model_sum());
`endif
        check_run_timing("gaps");
        check_load("gaps");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_csum();
        int cyc;
        img = '{32'd1, 32'd2, 32'd3};
        pulse_go();
        wait_ready("csum_ok");
        send_img(1'b1, 0, cyc);
        send_check_word(32'd6);
        check_run_timing("csum_ok");
        check_load("csum_ok");
        pulse_go();
        wait_ready("csum_bad");
        send_img(1'b1, 0, cyc);
        send_check_word(32'd7);
        checks++;
        if ({error_o, cpu_rst_o, start_o, ready_o, done_o} !== 6'b101000) begin
            errors++;
            $display("FAIL csum_bad state: err=%b cpu_rst=%b start=%b ready=%b done=%b expected 10 1 0 0 0",
                     error_o, cpu_rst_o, start_o, ready_o, done_o);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (error_o !== 2'b10) begin
            errors++;
            $display("FAIL csum_bad hold: err=%b expected 10", error_o);
        end
        check_load("csum_bad");
    endtask
`endif

    task automatic test_back_to_back();
        int cyc;
        for (int k = 0; k < 3; k++) begin
            fill_random($urandom_range(1, 40));
            pulse_go();
            checks++;
            if ({cpu_rst_o, start_o, done_o} !== 3'b100) begin
                errors++;
                $display("FAIL b2b restart: cpu_rst=%b start=%b done=%b expected 1 0 0",
                         cpu_rst_o, start_o, done_o);
            end
            wait_ready("b2b");
            send_image(1, cyc);
            check_run_timing("b2b");
            check_load("b2b");
        end
    endtask

    task automatic test_overflow();
        int cyc;
        fill_random(DEPTH);
        pulse_go();
        wait_ready("overflow");
        send_img(1'b0, 0, cyc);
        checks++;
        if ({error_o, cpu_rst_o, start_o, ready_o, done_o} !== 6'b011000) begin
            errors++;
            $display("FAIL overflow state: err=%b cpu_rst=%b start=%b ready=%b done=%b expected 01 1 0 0 0",
                     error_o, cpu_rst_o, start_o, ready_o, done_o);
        end
        checks++;
        if (int'(word_count_o) !== DEPTH) begin
            errors++;
            $display("FAIL overflow count: got %0d expected %0d", word_count_o, DEPTH);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (error_o !== 2'b01 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow hold: err=%b cpu_rst=%b expected 01 1", error_o, cpu_rst_o);
        end
        check_load("overflow");
        pulse_go();
        checks++;
        if (error_o !== 2'b00 || word_count_o !== '0 || cpu_rst_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow restart: err=%b count=%0d cpu_rst=%b expected 00 0 1",
                     error_o, word_count_o, cpu_rst_o);
        end
        wait_ready("overflow_restart");
    endtask

    task automatic test_rst_midload();
        int cyc;
        reset_dut();
        fill_random(5);
        pulse_go();
        wait_ready("rst_mid");
        send_img(1'b0, 0, cyc);
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({ready_o, we_o, cpu_rst_o, start_o, done_o} !== 5'b00100 || waddr_o !== '0 ||
            wdata_o !== '0 || error_o !== 2'b00 || word_count_o !== '0) begin
            errors++;
            $display("FAIL rst_mid async: ready=%b we=%b cpu_rst=%b start=%b done=%b waddr=%h wdata=%h err=%b count=%0d expected reset values",
                     ready_o, we_o, cpu_rst_o, start_o, done_o, waddr_o, wdata_o, error_o, word_count_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0 || cpu_rst_o !== 1'b1 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid idle: ready=%b cpu_rst=%b we=%b expected 0 1 0", ready_o, cpu_rst_o, we_o);
        end
        fill_random(20);
        pulse_go();
        wait_ready("rst_mid_reload");
        send_image(1, cyc);
        check_run_timing("rst_mid_reload");
        check_load("rst_mid_reload");
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) obs_mem[a] = 32'hDEAD_BEEF;
        test_reset();
        test_basic();
        test_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_csum();
`endif
        test_back_to_back();
        test_overflow();
        test_rst_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
